// File: rtl/result_byte_streamer.sv
// result_byte_streamer: buffers result words in a small FIFO and streams each
// word MSB-first as W_DATA-wide bytes to a UART transmitter, one strobe per
// byte with a done handshake. Every FRAME_WORDS words a frame-done pulse is
// issued.
// Optional build macro STREAMER_CHECKSUM_EN: appends one XOR checksum byte,
// covering every data byte of the frame, before the frame-done pulse.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | nothing to send; wait for the FIFO to hold a word
// LOAD  | pop one word into the shift register, restart the byte index
// SEND  | wait for the transmitter to be free, then strobe one byte
// WAIT  | wait for the transmitter's byte-complete pulse
// CSUM  | strobe the frame checksum byte (checksum build only)
// DONE  | pulse frame done, clear the per-frame counters
module result_byte_streamer #(
    parameter int W_WORD      = 32,
    parameter int W_DATA      = 8,
    parameter int W_ADDR      = 4,
    parameter int FRAME_WORDS = 16
) (
    input  logic              i_clk,
    input  logic              i_Rst_L,
    input  logic              i_word_dv,
    input  logic [W_WORD-1:0] i_word,
    output logic              o_word_ready,
    output logic              o_tx_dv,
    output logic [W_DATA-1:0] o_tx_byte,
    input  logic              i_tx_active,
    input  logic              i_tx_done,
    output logic              o_frame_done,
    output logic              o_busy,
    output logic              o_overflow
);

    localparam int BYTES  = W_WORD / W_DATA;
    localparam int W_BIDX = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int W_WCNT = $clog2(FRAME_WORDS + 1);
    localparam int DEPTH  = 1 << W_ADDR;

    localparam logic [W_BIDX-1:0] LAST_BYTE = W_BIDX'(BYTES - 1);
    localparam logic [W_WCNT-1:0] LAST_WORD = W_WCNT'(FRAME_WORDS - 1);
    localparam logic [W_ADDR:0]   FULL_CNT  = (W_ADDR + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WAIT,
`ifdef STREAMER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE
    } state_t;

    // ---------------------------------------------------------------- FIFO
    logic [W_WORD-1:0] mem [DEPTH];
    logic [W_ADDR-1:0] wr_ptr;
    logic [W_ADDR-1:0] rd_ptr;
    logic [W_ADDR:0]   count;
    logic              ready_en;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    assign full         = (count == FULL_CNT);
    assign empty        = (count == '0);
    // Ready depends only on occupancy, so a same-cycle pop never opens a full FIFO.
    assign o_word_ready = ready_en & ~full;
    assign push         = i_word_dv & o_word_ready;

    // Word storage; contents need no reset because the pointers define validity.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_word;
        end
    end

    // FIFO pointers, occupancy, post-reset ready enable and sticky overflow flag.
    always_ff @(posedge i_clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ready_en   <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + W_ADDR'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + W_ADDR'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (W_ADDR + 1)'(1);
                2'b01:   count <= count - (W_ADDR + 1)'(1);
                default: count <= count;
            endcase
            if (i_word_dv && full) begin
                o_overflow <= 1'b1;
            end
        end
    end

    // ----------------------------------------------------------------- FSM
    state_t            state;
    state_t            state_nxt;
    logic [W_WORD-1:0] shreg;
    logic [W_WORD-1:0] shreg_nxt;
    logic [W_BIDX-1:0] byte_idx;
    logic [W_BIDX-1:0] byte_idx_nxt;
    logic [W_WCNT-1:0] word_cnt;
    logic [W_WCNT-1:0] word_cnt_nxt;
    logic              tx_dv_nxt;
    logic [W_DATA-1:0] tx_byte_nxt;
    logic              frame_done_nxt;
    logic              csum_in_flight;

`ifdef STREAMER_CHECKSUM_EN
    logic [W_DATA-1:0] checksum;
    logic [W_DATA-1:0] checksum_nxt;
    logic              csum_sent;
    logic              csum_sent_nxt;

    assign csum_in_flight = csum_sent;
`else
    assign csum_in_flight = 1'b0;
`endif

    assign o_busy = (state != S_IDLE) | ~empty;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_nxt      = state;
        shreg_nxt      = shreg;
        byte_idx_nxt   = byte_idx;
        word_cnt_nxt   = word_cnt;
        tx_dv_nxt      = 1'b0;
        tx_byte_nxt    = o_tx_byte;
        frame_done_nxt = 1'b0;
        pop            = 1'b0;
`ifdef STREAMER_CHECKSUM_EN
        checksum_nxt   = checksum;
        csum_sent_nxt  = csum_sent;
`endif
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                pop          = 1'b1;
                shreg_nxt    = mem[rd_ptr];
                byte_idx_nxt = '0;
                state_nxt    = S_SEND;
            end
            S_SEND: begin
                if (!i_tx_active) begin
                    tx_dv_nxt    = 1'b1;
                    tx_byte_nxt  = shreg[W_WORD-1 -: W_DATA];
`ifdef STREAMER_CHECKSUM_EN
                    checksum_nxt = checksum ^ shreg[W_WORD-1 -: W_DATA];
`endif
                    state_nxt    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_tx_done) begin
                    if (csum_in_flight) begin
`ifdef STREAMER_CHECKSUM_EN
                        csum_sent_nxt = 1'b0;
`endif
                        state_nxt = S_DONE;
                    end else if (byte_idx != LAST_BYTE) begin
                        byte_idx_nxt = byte_idx + W_BIDX'(1);
                        shreg_nxt    = shreg << W_DATA;
                        state_nxt    = S_SEND;
                    end else begin
                        word_cnt_nxt = word_cnt + W_WCNT'(1);
                        if (word_cnt == LAST_WORD) begin
`ifdef STREAMER_CHECKSUM_EN
                            state_nxt = S_CSUM;
`else
                            state_nxt = S_DONE;
`endif
                        end else if (!empty) begin
                            state_nxt = S_LOAD;
                        end else begin
                            state_nxt = S_IDLE;
                        end
                    end
                end
            end
`ifdef STREAMER_CHECKSUM_EN
            S_CSUM: begin
                if (!i_tx_active) begin
                    tx_dv_nxt     = 1'b1;
                    tx_byte_nxt   = checksum;
                    csum_sent_nxt = 1'b1;
                    state_nxt     = S_WAIT;
                end
            end
`endif
            S_DONE: begin
                frame_done_nxt = 1'b1;
                word_cnt_nxt   = '0;
`ifdef STREAMER_CHECKSUM_EN
                checksum_nxt   = '0;
`endif
                state_nxt      = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge i_clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state        <= S_IDLE;
            shreg        <= '0;
            byte_idx     <= '0;
            word_cnt     <= '0;
            o_tx_dv      <= 1'b0;
            o_tx_byte    <= '0;
            o_frame_done <= 1'b0;
`ifdef STREAMER_CHECKSUM_EN
            checksum     <= '0;
            csum_sent    <= 1'b0;
`endif
        end else begin
            state        <= state_nxt;
            shreg        <= shreg_nxt;
            byte_idx     <= byte_idx_nxt;
            word_cnt     <= word_cnt_nxt;
            o_tx_dv      <= tx_dv_nxt;
            o_tx_byte    <= tx_byte_nxt;
            o_frame_done <= frame_done_nxt;
`ifdef STREAMER_CHECKSUM_EN
            checksum     <= checksum_nxt;
            csum_sent    <= csum_sent_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_result_byte_streamer.sv
// Self-checking bench for result_byte_streamer (default parameters).
// Expected bytes are queued when words are accepted and compared as the DUT
// strobes them; a responder returns i_tx_done a fixed delay after each strobe.
module tb_result_byte_streamer;

    logic        i_clk = 1'b0;
    logic        i_Rst_L;
    logic        i_word_dv;
    logic [31:0] i_word;
    logic        o_word_ready;
    logic        o_tx_dv;
    logic [7:0]  o_tx_byte;
    logic        i_tx_active;
    logic        i_tx_done;
    logic        o_frame_done;
    logic        o_busy;
    logic        o_overflow;

    result_byte_streamer #(
        .W_WORD(32), .W_DATA(8), .W_ADDR(4), .FRAME_WORDS(16)
    ) dut (
        .i_clk(i_clk), .i_Rst_L(i_Rst_L),
        .i_word_dv(i_word_dv), .i_word(i_word), .o_word_ready(o_word_ready),
        .o_tx_dv(o_tx_dv), .o_tx_byte(o_tx_byte),
        .i_tx_active(i_tx_active), .i_tx_done(i_tx_done),
        .o_frame_done(o_frame_done), .o_busy(o_busy), .o_overflow(o_overflow)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] word;
        logic [7:0]  b0, b1, b2, b3;
    } vec_t;

    vec_t       tbl [14];
    logic [7:0] exp_q [$];
    logic [7:0] csum = 8'h00;
    int         mw_cnt = 0;
    int         frames_exp = 0;
    int         frames_seen = 0;
    int         bytes_seen = 0;
    int         compared = 0;
    int         mismatched = 0;
    int         rst_gen = 0;
    int         last_wcyc = 0;
    bit         auto_done = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_bytes(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3);
        exp_q.push_back(b0); exp_q.push_back(b1);
        exp_q.push_back(b2); exp_q.push_back(b3);
        csum = csum ^ b0 ^ b1 ^ b2 ^ b3;
        mw_cnt++;
        if (mw_cnt == 16) begin
`ifdef STREAMER_CHECKSUM_EN
            exp_q.push_back(csum);
`endif
            csum = 8'h00;
            mw_cnt = 0;
            frames_exp++;
        end
    endtask

    task automatic model_word(input logic [31:0] w);
        model_bytes(w[31:24], w[23:16], w[15:8], w[7:0]);
    endtask

    task automatic push_word(input logic [31:0] w);
        i_word_dv = 1'b1;
        i_word    = w;
        @(posedge i_clk);
        #1;
        last_wcyc = cyc;
        i_word_dv = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_dv"},      32'(o_tx_dv),      32'd0);
        check({tag, "_tx_byte"},    32'(o_tx_byte),    32'd0);
        check({tag, "_frame_done"}, 32'(o_frame_done), 32'd0);
        check({tag, "_overflow"},   32'(o_overflow),   32'd0);
        check({tag, "_busy"},       32'(o_busy),       32'd0);
        check({tag, "_word_ready"}, 32'(o_word_ready), 32'd0);
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge i_clk);
            if (!o_busy && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(posedge i_clk);
        #1;
        check(name, 32'(ok), 32'd1);
        check({name, "_frames"}, 32'(frames_seen), 32'(frames_exp));
    endtask

    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge i_clk);
            if (i_Rst_L) begin
                if (o_tx_dv) begin
                    bytes_seen++;
                    if (exp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL tx_byte_extra: got 0x%0h, expected no byte (t=%0t)", o_tx_byte, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_byte", 32'(o_tx_byte), 32'(e));
                    end
                end
                if (o_frame_done) frames_seen++;
            end
        end
    endtask

    task automatic responder();
        logic [7:0] cap;
        int         gen;
        forever begin
            @(negedge i_clk);
            if (i_Rst_L && o_tx_dv && auto_done) begin
                cap = o_tx_byte;
                gen = rst_gen;
                repeat (9) @(posedge i_clk);
                #1;
                if (gen == rst_gen) begin
                    check("tx_byte_hold", 32'(o_tx_byte), 32'(cap));
                    i_tx_done = 1'b1;
                    @(posedge i_clk);
                    #1;
                    i_tx_done = 1'b0;
                end
            end
        end
    endtask

    initial begin
        int   base;
        int   acc;
        int   dcyc;
        logic rdy;

        tbl[0]  = '{32'hDEADBEEF, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        tbl[1]  = '{32'h00000000, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[2]  = '{32'hFFFFFFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        tbl[3]  = '{32'hA5A5A5A5, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
        tbl[4]  = '{32'h5A5A5A5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
        tbl[5]  = '{32'h01020304, 8'h01, 8'h02, 8'h03, 8'h04};
        tbl[6]  = '{32'h80000001, 8'h80, 8'h00, 8'h00, 8'h01};
        tbl[7]  = '{32'h12345678, 8'h12, 8'h34, 8'h56, 8'h78};
        tbl[8]  = '{32'h87654321, 8'h87, 8'h65, 8'h43, 8'h21};
        tbl[9]  = '{32'hF0E1D2C3, 8'hF0, 8'hE1, 8'hD2, 8'hC3};
        tbl[10] = '{32'h0F1E2D3C, 8'h0F, 8'h1E, 8'h2D, 8'h3C};
        tbl[11] = '{32'h00FF00FF, 8'h00, 8'hFF, 8'h00, 8'hFF};
        tbl[12] = '{32'hFF00FF00, 8'hFF, 8'h00, 8'hFF, 8'h00};
        tbl[13] = '{32'h13579BDF, 8'h13, 8'h57, 8'h9B, 8'hDF};

        i_Rst_L = 1'b0; i_word_dv = 1'b0; i_word = '0;
        i_tx_active = 1'b0; i_tx_done = 1'b0;

        fork
            monitor();
            responder();
            begin
                #500000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset values, ready comes up on the first edge after release.
        repeat (3) @(posedge i_clk);
        #1;
        check_reset_outputs("rst");
        @(negedge i_clk);
        i_Rst_L = 1'b1;
        #1;
        check("ready_before_edge", 32'(o_word_ready), 32'd0);
        @(posedge i_clk);
        #1;
        check("ready_after_edge", 32'(o_word_ready), 32'd1);

        // Single word into an idle block: byte order and first-strobe latency.
        model_word(32'h11223344);
        push_word(32'h11223344);
        dcyc = -100;
        for (int k = 0; k < 8; k++) begin
            @(negedge i_clk);
            if (o_tx_dv) begin
                dcyc = cyc;
                break;
            end
        end
        check("first_dv_latency", 32'(dcyc - last_wcyc), 32'd3);
        wait_idle("drain_single");

        // Transmitter busy holds the strobe off until it frees up.
        @(posedge i_clk); #1;
        i_tx_active = 1'b1;
        base = bytes_seen;
        model_word(32'hCAFEF00D);
        push_word(32'hCAFEF00D);
        repeat (12) @(posedge i_clk);
        #1;
        check("no_dv_while_active", 32'(bytes_seen), 32'(base));
        check("busy_while_active", 32'(o_busy), 32'd1);
        i_tx_active = 1'b0;
        wait_idle("drain_active");
        check("bytes_after_active", 32'(bytes_seen), 32'(base + 4));

        // Table vectors complete the first frame (16 words).
        for (int i = 0; i < 14; i++) begin
            model_bytes(tbl[i].b0, tbl[i].b1, tbl[i].b2, tbl[i].b3);
            push_word(tbl[i].word);
        end
        wait_idle("drain_frame1");

        // Counting frame 0x00000001..0x00000010.
        for (int i = 1; i <= 16; i++) begin
            model_word(32'(i));
            push_word(32'(i));
        end
        wait_idle("drain_frame2");

        // Overflow: done withheld, one word parked in the shift register.
        auto_done = 1'b0;
        base = bytes_seen;
        acc = 0;
        check("overflow_before", 32'(o_overflow), 32'd0);
        for (int i = 0; i < 18; i++) begin
            rdy = o_word_ready;
            i_word_dv = 1'b1;
            i_word = 32'h55000000 + 32'(i);
            @(posedge i_clk);
            #1;
            if (rdy) begin
                acc++;
                model_word(32'h55000000 + 32'(i));
            end
        end
        i_word_dv = 1'b0;
        check("accepted_words", 32'(acc), 32'd17);
        check("overflow_set", 32'(o_overflow), 32'd1);
        check("ready_when_full", 32'(o_word_ready), 32'd0);
        check("one_byte_in_flight", 32'(bytes_seen), 32'(base + 1));
        auto_done = 1'b1;
        i_tx_done = 1'b1;
        @(posedge i_clk);
        #1;
        i_tx_done = 1'b0;
        wait_idle("drain_overflow");
        check("overflow_sticky", 32'(o_overflow), 32'd1);

        // Reset after five bytes abandons the frame.
        base = bytes_seen;
        for (int i = 0; i < 4; i++) begin
            model_word(32'hA0B0C0D0 + 32'(i));
            push_word(32'hA0B0C0D0 + 32'(i));
        end
        dcyc = 0;
        for (int k = 0; k < 500; k++) begin
            @(negedge i_clk);
            if (bytes_seen >= base + 5) begin
                dcyc = 1;
                break;
            end
        end
        check("reached_five_bytes", 32'(dcyc), 32'd1);
        #1;
        i_Rst_L = 1'b0;
        rst_gen++;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        mw_cnt = 0;
        csum = 8'h00;
        repeat (12) @(posedge i_clk);
        @(negedge i_clk);
        i_Rst_L = 1'b1;
        repeat (4) @(posedge i_clk);
        #1;
        check("no_frame_done_abandoned", 32'(frames_seen), 32'(frames_exp));
        check("no_bytes_after_reset", 32'(bytes_seen), 32'(base + 5));

        // Fresh frame after reset: full word count and new checksum.
        for (int i = 0; i < 16; i++) begin
            model_word(32'h80000000 + 32'(i * 3));
            push_word(32'h80000000 + 32'(i * 3));
        end
        wait_idle("drain_frame_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
